// File: rtl/dm_pkg.sv
// Shared encodings and lane helpers for the dm_resp data-memory responder.
// Optional build macro used by the top: DM_INIT_CLEAR_EN.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_READ  = 3'd1;
  localparam state_t ST_ALIGN = 3'd2;
  localparam state_t ST_RESP  = 3'd3;
  localparam state_t ST_CLEAR = 3'd4;

  // Reserved size is reported through the same error path as misalignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lo[0];
      SZ_WORD: misaligned = (lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lo;
      SZ_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: replicate = {4{data[7:0]}};
      SZ_HALF: replicate = {2{data[15:0]}};
      default: replicate = data;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic sgn, input logic [1:0] lo);
    logic [31:0] sh;
    sh = '0;
    case (size)
      SZ_BYTE: begin
        sh = word >> {lo, 3'b000};
        load_extend = {{24{sgn & sh[7]}}, sh[7:0]};
      end
      SZ_HALF: begin
        sh = word >> {lo[1], 4'b0000};
        load_extend = {{16{sgn & sh[15]}}, sh[15:0]};
      end
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Single-port synchronous RAM, DEPTH x 32, byte-enable write and registered read.
module dm_ram #(
  parameter int DEPTH = 4096,
  parameter int IDX_W = 12
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [3:0]       we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // NOTE: the array has no reset so it maps onto a RAM macro; contents are X until written.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      rdata_o <= mem_q[idx_i];
    end
  end

endmodule

// File: rtl/dm_resp.sv
// Data-memory responder: valid/ready load/store front end over dm_ram.
// Build macro DM_INIT_CLEAR_EN adds a post-reset CLEAR pass zeroing every word.
module dm_resp
  import dm_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = ADDR_W - 2;

  state_t            state_q, state_d;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              accept;

  logic              ram_en;
  logic [3:0]        ram_we;
  logic [IDX_W-1:0]  ram_idx;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

`ifdef DM_INIT_CLEAR_EN
  logic [IDX_W-1:0]  clr_q, clr_d;
`endif

  // Gated with reset so nothing is accepted in the reset cycle itself.
  assign req_ready  = (state_q == ST_IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_idx   = addr_q[ADDR_W-1:2];
    ram_wdata = '0;
`ifdef DM_INIT_CLEAR_EN
    clr_d     = clr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (misaligned(req_size, req_addr[1:0])) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = ST_RESP;
          end else if (req_we) begin
            // Stores commit on the accept edge itself.
            ram_en    = 1'b1;
            ram_we    = byte_en(req_size, req_addr[1:0]);
            ram_idx   = req_addr[ADDR_W-1:2];
            ram_wdata = replicate(req_size, req_wdata);
            err_d     = 1'b0;
            rdata_d   = '0;
            state_d   = ST_RESP;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        ram_en  = 1'b1;
        state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        rdata_d = load_extend(ram_rdata, size_q, signed_q, addr_q[1:0]);
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
`ifdef DM_INIT_CLEAR_EN
      ST_CLEAR: begin
        ram_en  = 1'b1;
        ram_we  = 4'b1111;
        ram_idx = clr_q;
        clr_d   = clr_q + 1'b1;
        if (clr_q == IDX_W'(DEPTH - 1)) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef DM_INIT_CLEAR_EN
      state_q <= ST_CLEAR;
      clr_q   <= '0;
`else
      state_q <= ST_IDLE;
`endif
      rdata_q  <= '0;
      err_q    <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef DM_INIT_CLEAR_EN
      clr_q   <= clr_d;
`endif
      if (accept) begin
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
      end
    end
  end

  dm_ram #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_ram (
    .clk    (clk),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .idx_i  (ram_idx),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

endmodule

// File: tb/tb_dm_resp.sv
// Self-checking bench for dm_resp: vector table plus back-pressure and reset sequences.
module tb_dm_resp;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string             name;
    logic              we;
    logic [1:0]        size;
    logic              sgn;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       exp_rdata;
    logic              exp_err;
  } vec_t;

  vec_t vecs[$];

  dm_resp #(.ADDR_W(ADDR_W), .DEPTH(4096)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_signed(req_signed),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic [1:0] size,
                              input logic sgn, input logic [ADDR_W-1:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.sgn = sgn; v.addr = addr;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  // Waits (bounded) for req_ready, performs one accept, then counts cycles to resp_valid.
  task automatic issue(input vec_t v, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 5000) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic do_req(input vec_t v);
    int lat;
    int exp_lat;
    exp_lat = (v.we || v.exp_err) ? 1 : 3;
    issue(v, lat);
    check({v.name, " rdata"}, resp_rdata, v.exp_rdata);
    check({v.name, " err"}, {31'd0, resp_err}, {31'd0, v.exp_err});
    check({v.name, " latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (!req_ready && n < 6000) begin @(posedge clk); #1; n++; end
    check(name, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    int lat;
    logic seen;
    vec_t v;

    vecs.push_back(mk("st_w_10",     1, 2'b10, 0, 14'h0010, 32'h12345678, 32'h00000000, 0));
    vecs.push_back(mk("ld_w_10",     0, 2'b10, 0, 14'h0010, 32'h0,        32'h12345678, 0));
    vecs.push_back(mk("st_b_11",     1, 2'b00, 0, 14'h0011, 32'hFFFFFFAB, 32'h00000000, 0));
    vecs.push_back(mk("ld_bs_11",    0, 2'b00, 1, 14'h0011, 32'h0,        32'hFFFFFFAB, 0));
    vecs.push_back(mk("ld_bu_11",    0, 2'b00, 0, 14'h0011, 32'h0,        32'h000000AB, 0));
    vecs.push_back(mk("ld_w_10b",    0, 2'b10, 0, 14'h0010, 32'h0,        32'h1234AB78, 0));
    vecs.push_back(mk("ld_hs_10",    0, 2'b01, 1, 14'h0010, 32'h0,        32'hFFFFAB78, 0));
    vecs.push_back(mk("ld_hu_12",    0, 2'b01, 0, 14'h0012, 32'h0,        32'h00001234, 0));
    vecs.push_back(mk("st_w_20",     1, 2'b10, 0, 14'h0020, 32'hCAFEF00D, 32'h00000000, 0));
    vecs.push_back(mk("st_h_22",     1, 2'b01, 0, 14'h0022, 32'hDEAD8001, 32'h00000000, 0));
    vecs.push_back(mk("ld_hs_22",    0, 2'b01, 1, 14'h0022, 32'h0,        32'hFFFF8001, 0));
    vecs.push_back(mk("ld_hu_22",    0, 2'b01, 0, 14'h0022, 32'h0,        32'h00008001, 0));
    vecs.push_back(mk("ld_w_20",     0, 2'b10, 0, 14'h0020, 32'h0,        32'h8001F00D, 0));
    vecs.push_back(mk("err_ld_w_13", 0, 2'b10, 0, 14'h0013, 32'h0,        32'h00000000, 1));
    vecs.push_back(mk("err_ld_h_05", 0, 2'b01, 1, 14'h0005, 32'h0,        32'h00000000, 1));
    vecs.push_back(mk("err_ld_rsvd", 0, 2'b11, 0, 14'h0010, 32'h0,        32'h00000000, 1));
    vecs.push_back(mk("err_st_w_12", 1, 2'b10, 0, 14'h0012, 32'hFFFFFFFF, 32'h00000000, 1));
    vecs.push_back(mk("err_st_rsvd", 1, 2'b11, 0, 14'h0010, 32'h00000000, 32'h00000000, 1));
    vecs.push_back(mk("err_st_h_11", 1, 2'b01, 0, 14'h0011, 32'h00000000, 32'h00000000, 1));
    vecs.push_back(mk("ld_w_10_kept",0, 2'b10, 0, 14'h0010, 32'h0,        32'h1234AB78, 0));
    vecs.push_back(mk("st_w_3ffc",   1, 2'b10, 0, 14'h3FFC, 32'hA5A55A5A, 32'h00000000, 0));
    vecs.push_back(mk("ld_w_3ffc",   0, 2'b10, 0, 14'h3FFC, 32'h0,        32'hA5A55A5A, 0));
    vecs.push_back(mk("ld_bu_3fff",  0, 2'b00, 0, 14'h3FFF, 32'h0,        32'h000000A5, 0));
    vecs.push_back(mk("ld_bs_3ffe",  0, 2'b00, 1, 14'h3FFE, 32'h0,        32'hFFFFFFA5, 0));
    vecs.push_back(mk("ld_bs_3ffc",  0, 2'b00, 1, 14'h3FFC, 32'h0,        32'h0000005A, 0));
    vecs.push_back(mk("st_b_03",     1, 2'b00, 0, 14'h0003, 32'h1234567F, 32'h00000000, 0));
    vecs.push_back(mk("ld_bs_03",    0, 2'b00, 1, 14'h0003, 32'h0,        32'h0000007F, 0));

    // Reset state, sampled during the reset cycles.
    repeat (3) @(posedge clk);
    #1;
    check("rst req_ready", {31'd0, req_ready}, 32'd0);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst resp_err", {31'd0, resp_err}, 32'd0);
    reset = 1'b0;
    #1;
`ifdef DM_INIT_CLEAR_EN
    wait_ready("clear ready delay", 4096);
    do_req(mk("ld_w_3ffc_clr", 0, 2'b10, 0, 14'h3FFC, 32'h0, 32'h00000000, 0));
`else
    check("ready after release", {31'd0, req_ready}, 32'd1);
`endif

    foreach (vecs[i]) do_req(vecs[i]);

    // Back-pressure: response held 5 cycles with resp_ready low.
    resp_ready = 1'b0;
    v = mk("bp_ld_w_10", 0, 2'b10, 0, 14'h0010, 32'h0, 32'h1234AB78, 0);
    issue(v, lat);
    check("bp latency", 32'(lat), 32'd3);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp resp_valid held", {31'd0, resp_valid}, 32'd1);
      check("bp rdata held", resp_rdata, 32'h1234AB78);
      check("bp req_ready low", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp resp_valid drop", {31'd0, resp_valid}, 32'd0);
    check("bp req_ready back", {31'd0, req_ready}, 32'd1);

    // Store throughput with resp_ready high: next accept two cycles after the first.
    do_req(mk("st_w_40", 1, 2'b10, 0, 14'h0040, 32'h0BADBEEF, 32'h00000000, 0));
    do_req(mk("ld_w_40_raw", 0, 2'b10, 0, 14'h0040, 32'h0, 32'h0BADBEEF, 0));

    // Reset while a load sits in READ: the load is cancelled.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 14'h0040;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstmid resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rstmid req_ready", {31'd0, req_ready}, 32'd0);
    check("rstmid rdata", resp_rdata, 32'd0);
    reset = 1'b0;
    #1;
`ifdef DM_INIT_CLEAR_EN
    wait_ready("rstmid clear delay", 4096);
    do_req(mk("ld_w_3ffc_clr2", 0, 2'b10, 0, 14'h3FFC, 32'h0, 32'h00000000, 0));
`else
    check("rstmid ready after release", {31'd0, req_ready}, 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    check("rstmid load cancelled", {31'd0, seen}, 32'd0);
    do_req(mk("ld_w_10_after_rst", 0, 2'b10, 0, 14'h0010, 32'h0, 32'h1234AB78, 0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_resp.md
Name: dm_resp

Overview:
- Data-memory responder at the far end of the ALU address path (dm_addr, 14-bit byte address).
- Accepts load/store requests from the datapath through a valid/ready handshake.
- Performs byte, half-word and word accesses on an internal word-organised RAM, and returns load data or store completion through a valid/ready response channel.
- Replaces the combinational data-memory model so that memory latency becomes explicit.

Parameters:
- ADDR_W, 14: byte-address width (matches dm_addr).
- DEPTH, 4096: RAM depth in 32-bit words; equals 2^(ADDR_W-2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  loads only: sign-extend byte/half.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  load data, extended; 0 for stores and errors.
- resp_err  out  1  misaligned address or reserved size.

Behaviour:
- Reset values:
  - req_ready = 0 in the reset cycle, 1 from the first cycle after reset is released.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, state = IDLE.
  - RAM contents are not reset.
- Handshake:
  - A request transfers when req_valid && req_ready at a rising edge. The request fields are captured into registers.
  - A response transfers when resp_valid && resp_ready.
  - resp_rdata and resp_err are stable while resp_valid=1 and resp_ready=0.
  - One outstanding request maximum. req_ready=1 only in IDLE.
- FSM states:
  - IDLE:
    - On accept with an error (size 11, half with addr[0]=1, word with addr[1:0]!=0), go to RESP with err=1 and no RAM access.
    - On accept of a valid store, write the RAM this edge using byte enables, then go to RESP with rdata=0.
    - On accept of a valid load, go to READ.
  - READ: the synchronous RAM read issues on word index addr[ADDR_W-1:2]. Go to ALIGN.
  - ALIGN:
    - Select the lane from addr[1:0] (byte: lane addr[1:0]; half: lane addr[1]).
    - Zero- or sign-extend per req_signed; word loads ignore req_signed.
    - Register the result into resp_rdata. Go to RESP.
  - RESP: resp_valid=1. On resp_ready, go to IDLE and deassert resp_valid next cycle.
- Latency, measured from the accept edge to the first cycle resp_valid=1:
  - store / error: 1 cycle.
  - load: 3 cycles.
  - Back-to-back throughput: 1 request per 2 cycles (stores) or 4 cycles (loads) with resp_ready tied high.
- Byte enables:
  - byte: 1<<addr[1:0], data replicated across all lanes.
  - half: 0011 or 1100 per addr[1], data replicated.
  - word: 1111.
- Endianness: little-endian; lane 0 = bits [7:0].
- Boundaries:
  - Highest address 0x3FFC word is accessible.
  - Addresses never wrap (ADDR_W bits map exactly onto DEPTH).
- Reset mid-operation: reset asserted in any state forces IDLE, drops resp_valid, and cancels a pending load. A store already written on the accept edge stays written.
- Read-after-write: a load accepted the cycle after a store's response to the same word returns the new data.

Optional Feature:
- Macro: DM_INIT_CLEAR_EN.
- Defined:
  - After reset deasserts, the FSM enters a CLEAR state and writes 0 to word indices 0..DEPTH-1, one per cycle.
  - req_ready stays 0 for DEPTH cycles, then the FSM goes to IDLE.
  - Reset during CLEAR restarts the clear from index 0.
- Undefined: no CLEAR state; RAM holds X until written; req_ready=1 the first cycle after reset.

Decomposition:
- Package dm_pkg:
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD.
  - FSM state enum (IDLE, READ, ALIGN, RESP, CLEAR).
  - function for the misalignment check.
- Sub-module dm_ram: single-port synchronous RAM, DEPTH x 32, 4-bit byte-enable write, registered read; this is the natural RAM-inference boundary.

Test Plan:
- Store word 0x12345678 at addr 0x0010, then load word 0x0010 -> resp_rdata=0x12345678, err=0, resp_valid 3 cycles after load accept.
- After the word above, store byte 0xAB at 0x0011; load byte signed 0x0011 -> 0xFFFFFFAB; load byte unsigned -> 0x000000AB; load word 0x0010 -> 0x1234AB78.
- Store half 0x8001 at 0x0022; load half signed 0x0022 -> 0xFFFF8001; load half unsigned -> 0x00008001.
- Load word at 0x0013, half at 0x0005, and req_size=11 -> resp_err=1, rdata=0, 1-cycle latency; RAM contents unchanged (verified by readback).
- Hold resp_ready=0 for 5 cycles during a load response -> resp_valid and resp_rdata held stable, req_ready=0 throughout; accept after resp_ready=1.
- Assert reset during READ -> resp_valid=0 next cycle, req_ready=1 after release. With DM_INIT_CLEAR_EN: req_ready=1 only after 4096 cycles, and a load of 0x3FFC returns 0.
